// File: rtl/rand_word_fifo.sv
// rtl/rand_word_fifo.sv - LFSR random word generator feeding a first-word-fall-through FIFO
//
// A 32-bit Galois LFSR (x^32+x^22+x^2+x+1) produces one word every GAP enabled
// cycles into a DEPTH-entry FWFT FIFO whose head is presented on rand_out.
//
// Ports:
//   clk         in   1            clock, all state on rising edge
//   rst         in   1            synchronous reset, active high
//   seed_we     in   1            load seed_in into LFSR and flush FIFO
//   seed_in     in   32           seed value (0 selects SEED)
//   enable      in   1            LFSR steps and gap counter runs
//   pop         in   1            consumer removes head word
//   rand_out    out  32           head word, 0 when empty
//   rand_valid  out  1            FIFO non-empty
//   level       out  LOG_DEPTH+1  stored words, 0..DEPTH
//   underflow   out  1            pulse: pop arrived while empty
module rand_word_fifo #(
    parameter int          DEPTH     = 4,
    parameter int          LOG_DEPTH = 2,
    parameter int          GAP       = 8,
    parameter logic [31:0] SEED      = 32'hACE10001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_we,
    input  logic [31:0]          seed_in,
    input  logic                 enable,
    input  logic                 pop,
    output logic [31:0]          rand_out,
    output logic                 rand_valid,
    output logic [LOG_DEPTH:0]   level,
    output logic                 underflow
);

    localparam int                 CW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(GAP - 1);
    localparam logic [LOG_DEPTH:0] FULL     = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [31:0]        POLY     = 32'h80200003;

    logic [31:0]          lfsr_q, lfsr_d, lfsr_nxt;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH:0]   level_q, level_d;
    logic                 underflow_q, underflow_d;
    logic [31:0]          mem_q [DEPTH];
    logic                 push;
    logic                 do_pop;
    logic                 has_space;

    always_comb begin
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        underflow_d = 1'b0;
        push        = 1'b0;
        do_pop      = 1'b0;

        lfsr_nxt  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
        // A pop of a non-empty FIFO frees a slot in the same cycle, so a
        // stalled word can land while the FIFO is full.
        has_space = (level_q < FULL) || (pop && (level_q != '0));

        if (seed_we) begin
            lfsr_d   = (seed_in == 32'h0) ? SEED : seed_in;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            do_pop      = pop && (level_q != '0);
            underflow_d = pop && (level_q == '0);

            if (enable) begin
                lfsr_d = lfsr_nxt;
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (has_space) begin
                    push  = 1'b1;
                    cnt_d = '0;
                end
                // otherwise cnt holds at GAP-1 until space appears
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !do_pop) begin
                level_d = level_q + 1'b1;
            end else if (do_pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= SEED;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: contents are only visible while level != 0.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= lfsr_q;
        end
    end

    assign rand_valid = (level_q != '0);
    assign rand_out   = rand_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign level      = level_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_rand_word_fifo.sv
// tb/tb_rand_word_fifo.sv - scoreboard bench for rand_word_fifo
module tb_rand_word_fifo;

    localparam logic [31:0] SEED = 32'hACE10001;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_we;
    logic [31:0] seed_in;
    logic        enable;
    logic        pop;
    logic [31:0] rand_out;
    logic        rand_valid;
    logic [2:0]  level;
    logic        underflow;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] prev;

    rand_word_fifo #(
        .DEPTH(4), .LOG_DEPTH(2), .GAP(8), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed_in(seed_in),
        .enable(enable), .pop(pop), .rand_out(rand_out),
        .rand_valid(rand_valid), .level(level), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_n(input logic [31:0] s, input int n);
        logic [31:0] v = s;
        for (int i = 0; i < n; i++) begin
            v = (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic p, input logic sw, input logic [31:0] si);
        enable  = en;
        pop     = p;
        seed_we = sw;
        seed_in = si;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted pop of a valid head is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && !seed_we && pop && rand_valid) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", rand_out, 32'hxxxxxxxx);
            end else begin
                check("pop_word", rand_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; seed_we = 1'b0; seed_in = 32'h0; enable = 1'b0; pop = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            seed_we = 1'($urandom); seed_in = $urandom; enable = 1'($urandom); pop = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_rand_out", rand_out, 32'h0);
            check("rst_valid", 32'(rand_valid), 32'h0);
            check("rst_level", 32'(level), 32'h0);
            check("rst_underflow", 32'(underflow), 32'h0);
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        check("post_rst_level", 32'(level), 32'h0);

        // First word after reset is SEED stepped 7 times
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        check("rst_word_level", 32'(level), 32'h1);
        check("rst_word", rand_out, lfsr_n(SEED, 7));
        exp_q.push_back(lfsr_n(SEED, 7));
        cyc(0, 1, 0, 0);
        check("rst_word_popped", 32'(level), 32'h0);

        // Seed 1 / first word
        cyc(0, 0, 1, 32'h1);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        check("seed1_valid", 32'(rand_valid), 32'h1);
        check("seed1_word", rand_out, 32'hB62D8003);
        check("seed1_level", 32'(level), 32'h1);
        exp_q.push_back(32'hB62D8003);

        // Fill and stall
        for (int i = 0; i < 24; i++) cyc(1, 0, 0, 0);
        check("fill_level", 32'(level), 32'h4);
        for (int k = 2; k <= 4; k++) exp_q.push_back(lfsr_n(32'h1, 8 * k - 1));
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
        check("stall_level", 32'(level), 32'h4);
        cyc(1, 1, 0, 0);
        check("stall_pop_level", 32'(level), 32'h4);
        check("stall_head", rand_out, lfsr_n(32'h1, 15));
        exp_q.push_back(lfsr_n(32'h1, 52));
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        check("drain_level", 32'(level), 32'h0);

        // Underflow
        cyc(0, 1, 0, 0);
        check("uf_pulse", 32'(underflow), 32'h1);
        check("uf_level", 32'(level), 32'h0);
        cyc(0, 0, 0, 0);
        check("uf_clear", 32'(underflow), 32'h0);
        cyc(0, 0, 1, 32'h9);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("uf_push_pulse", 32'(underflow), 32'h1);
        check("uf_push_level", 32'(level), 32'h1);
        check("uf_push_word", rand_out, lfsr_n(32'h9, 7));
        exp_q.push_back(lfsr_n(32'h9, 7));
        cyc(0, 0, 0, 0);
        check("uf_push_clear", 32'(underflow), 32'h0);
        cyc(0, 1, 0, 0);

        // Zero seed with same-cycle pop flushes
        cyc(0, 0, 1, 32'h5);
        for (int i = 0; i < 24; i++) cyc(1, 0, 0, 0);
        check("flush_pre_level", 32'(level), 32'h3);
        cyc(0, 1, 1, 32'h0);
        check("flush_level", 32'(level), 32'h0);
        check("flush_valid", 32'(rand_valid), 32'h0);
        check("flush_underflow", 32'(underflow), 32'h0);
        check("flush_rand_out", rand_out, 32'h0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        check("zero_seed_word", rand_out, lfsr_n(SEED, 7));
        exp_q.push_back(lfsr_n(SEED, 7));
        cyc(0, 1, 0, 0);

        // Enable gating
        cyc(0, 0, 1, 32'h1);
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                cyc(1, 0, 0, 0);
            end else begin
                prev = rand_out;
                cyc(0, 0, 0, 0);
                check("gate_hold", rand_out, prev);
            end
        end
        check("gate_level", 32'(level), 32'h2);
        exp_q.push_back(lfsr_n(32'h1, 7));
        exp_q.push_back(lfsr_n(32'h1, 15));
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("end_level", 32'(level), 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
